// File: rtl/hazard_unit.sv
// hazard_unit - pipeline hazard controller for the five-stage MIPS core.
//
// Tracks register writes in flight (EX, MEM, WB) in a three-slot scoreboard,
// reports read-after-write conflicts for the ID instruction's sources as a
// 2-bit pause code, converts the decoder's pause request into PC/IF-ID hold
// and ID/EX bubble controls, flushes IF/ID on redirect and counts stall
// cycles.
//
// Build option: define HAZARD_FORWARD_EN to enable EX/MEM/WB bypassing.
// Only load-use hazards then pause the pipe, and fwd_a_sel/fwd_b_sel exist.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   id_valid            ID stage holds a real instruction
//   id_rs, id_rt        ID source registers
//   id_we, id_wreg      ID instruction writes register id_wreg
//   id_is_load          ID instruction is a load
//   pause_req           decoder confirms it reads a conflicting source
//   redirect            ID resolved a taken branch/jump
//   pause_code          {rt hazard, rs hazard} to the decoder
//   pc_hold, ifid_hold  freeze PC and IF/ID
//   idex_bubble         load a NOP into ID/EX
//   ifid_flush          replace IF/ID with a NOP
//   fwd_a_sel/fwd_b_sel 00 regfile, 01 EX, 10 MEM, 11 WB (forwarding build)
//   stall_cnt           saturating stall-cycle count
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_we,
  input  logic [4:0]       id_wreg,
  input  logic             id_is_load,
  input  logic             pause_req,
  input  logic             redirect,
  output logic [1:0]       pause_code,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             ifid_flush,
`ifdef HAZARD_FORWARD_EN
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
`endif
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] r;
    logic       ld;
  } slot_t;

  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  slot_t            wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic haz_rs, haz_rt;
  logic stall;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic hit(input slot_t s, input logic [4:0] r);
    return s.v && (s.r == r) && (r != 5'd0);
  endfunction

`ifdef HAZARD_FORWARD_EN
  // A load sitting in EX has no result yet; the load-use stall covers it,
  // so it is skipped and never yields the EX select.
  function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem,
                                         input slot_t wb, input logic [4:0] r);
    if (hit(ex, r) && !ex.ld) return 2'b01;
    else if (hit(mem, r))     return 2'b10;
    else if (hit(wb, r))      return 2'b11;
    else                      return 2'b00;
  endfunction
`endif

  always_comb begin
`ifdef HAZARD_FORWARD_EN
    haz_rs = hit(ex_q, id_rs) && ex_q.ld;
    haz_rt = hit(ex_q, id_rt) && ex_q.ld;
`else
    // The register file writes at the end of WB with no internal bypass,
    // so any in-flight writer blocks the read until it retires.
    haz_rs = hit(ex_q, id_rs) || hit(mem_q, id_rs) || hit(wb_q, id_rs);
    haz_rt = hit(ex_q, id_rt) || hit(mem_q, id_rt) || hit(wb_q, id_rt);
`endif
    pause_code = {haz_rt, haz_rs};
  end

  always_comb begin
    stall       = id_valid && pause_req;
    pc_hold     = stall;
    ifid_hold   = stall;
    idex_bubble = stall;
    // A stalled branch re-resolves next cycle with fresh operands.
    ifid_flush  = redirect && !stall;
  end

`ifdef HAZARD_FORWARD_EN
  always_comb begin
    fwd_a_sel = fwd_sel(ex_q, mem_q, wb_q, id_rs);
    fwd_b_sel = fwd_sel(ex_q, mem_q, wb_q, id_rt);
  end
`endif

  always_comb begin
    ex_d = '0;
    if (id_valid && id_we && (id_wreg != 5'd0) && !stall && !ifid_flush) begin
      ex_d = {1'b1, id_wreg, id_is_load};
    end
    mem_d = ex_q;
    wb_d  = mem_q;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

  // Load flags are carried down the scoreboard for visibility but only the
  // EX copy matters, and only when bypassing is built in.
  logic sb_unused;
`ifdef HAZARD_FORWARD_EN
  assign sb_unused = ^{mem_q.ld, wb_q.ld};
`else
  assign sb_unused = ^{ex_q.ld, mem_q.ld, wb_q.ld};
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_we, id_is_load, pause_req, redirect;
  logic [4:0] id_rs, id_rt, id_wreg;

  logic [1:0]  pause_code, pause_code2;
  logic        pc_hold, ifid_hold, idex_bubble, ifid_flush;
  logic        pc_hold2, ifid_hold2, idex_bubble2, ifid_flush2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;
`ifdef HAZARD_FORWARD_EN
  logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_sel2, fwd_b_sel2;
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_we(id_we), .id_wreg(id_wreg), .id_is_load(id_is_load),
    .pause_req(pause_req), .redirect(redirect), .pause_code(pause_code),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush),
`ifdef HAZARD_FORWARD_EN
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`endif
    .stall_cnt(stall_cnt)
  );

  hazard_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_we(id_we), .id_wreg(id_wreg), .id_is_load(id_is_load),
    .pause_req(pause_req), .redirect(redirect), .pause_code(pause_code2),
    .pc_hold(pc_hold2), .ifid_hold(ifid_hold2), .idex_bubble(idex_bubble2),
    .ifid_flush(ifid_flush2),
`ifdef HAZARD_FORWARD_EN
    .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2),
`endif
    .stall_cnt(stall_cnt2)
  );

  typedef struct {
    bit       valid;
    bit [4:0] rs, rt, wd;
    bit       we, ld, use_rs, use_rt, redir;
  } instr_t;

  // One record per instruction that entered EX; index 0 is the youngest.
  typedef struct {
    bit       v;
    bit [4:0] r;
    bit       ld;
  } wr_t;

  instr_t prog[$];
  instr_t cur;
  wr_t    hist[$];
  int     m_cnt;
  int     cyc;
  int     rst_at = -1;
  bit     rst_req;
  int     force_left;
  bit     random_mode;
  bit     checking;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] tr_pc[$], tr_bub[$], tr_flush[$], tr_sela[$], tr_selb[$];
  logic [15:0] tr_cnt[$], tr_cnt2[$];

  localparam instr_t NOP = '{valid: 1'b0, rs: 5'd0, rt: 5'd0, wd: 5'd0,
                             we: 1'b0, ld: 1'b0, use_rs: 1'b0, use_rt: 1'b0,
                             redir: 1'b0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reading r conflicts with an in-flight writer that has not yet produced
  // a usable value for that read.
  function automatic bit m_haz(input bit [4:0] r);
    if (r == 5'd0) return 1'b0;
`ifdef HAZARD_FORWARD_EN
    return hist[0].v && hist[0].r == r && hist[0].ld;
`else
    for (int a = 0; a < 3; a++)
      if (hist[a].v && hist[a].r == r) return 1'b1;
    return 1'b0;
`endif
  endfunction

  // Youngest usable producer of r: age 0 -> EX (1), 1 -> MEM (2), 2 -> WB (3).
  function automatic bit [1:0] m_sel(input bit [4:0] r);
    if (r == 5'd0) return 2'd0;
    for (int a = 0; a < 3; a++)
      if (hist[a].v && hist[a].r == r && !(a == 0 && hist[a].ld))
        return 2'(a + 1);
    return 2'd0;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.valid  = ($urandom % 10) != 0;
    i.rs     = 5'($urandom_range(0, 7));
    i.rt     = 5'($urandom_range(0, 7));
    i.we     = ($urandom % 4) != 0;
    i.wd     = 5'($urandom_range(0, 7));
    i.ld     = ($urandom % 3) == 0;
    i.use_rs = ($urandom % 4) != 0;
    i.use_rt = ($urandom % 2) != 0;
    i.redir  = i.valid && (($urandom % 8) == 0);
    return i;
  endfunction

  function automatic instr_t mk(input bit [4:0] rs, input bit [4:0] rt,
                                input bit we, input bit [4:0] wd, input bit ld,
                                input bit urs, input bit urt, input bit redir);
    instr_t i;
    i.valid = 1'b1; i.rs = rs; i.rt = rt; i.we = we; i.wd = wd; i.ld = ld;
    i.use_rs = urs; i.use_rt = urt; i.redir = redir;
    return i;
  endfunction

  task automatic step();
    bit [1:0] epc;
    bit       estall, eflush, fp;
    int       ecnt;
    wr_t      e;
    @(negedge clk);
    rst        = rst_req || (cyc == rst_at);
    fp         = force_left > 0;
    id_valid   = cur.valid;
    id_rs      = cur.rs;
    id_rt      = cur.rt;
    id_we      = cur.we;
    id_wreg    = cur.wd;
    id_is_load = cur.ld;
    redirect   = cur.redir;
    epc        = {m_haz(cur.rt), m_haz(cur.rs)};
    pause_req  = fp || (cur.valid && ((epc[0] && cur.use_rs) || (epc[1] && cur.use_rt)));
    estall     = cur.valid && pause_req;
    eflush     = cur.redir && !estall;
    #1;
    if (checking) begin
      ecnt = (m_cnt > 65535) ? 65535 : m_cnt;
      chk("pause_code", 32'(pause_code), 32'(epc));
      chk("pc_hold", 32'(pc_hold), 32'(estall));
      chk("ifid_hold", 32'(ifid_hold), 32'(estall));
      chk("idex_bubble", 32'(idex_bubble), 32'(estall));
      chk("ifid_flush", 32'(ifid_flush), 32'(eflush));
      chk("stall_cnt", 32'(stall_cnt), 32'(ecnt));
      chk("stall_cnt_w2", 32'(stall_cnt2), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
      chk("pause_code_w2", 32'(pause_code2), 32'(epc));
`ifdef HAZARD_FORWARD_EN
      chk("fwd_a_sel", 32'(fwd_a_sel), 32'(m_sel(cur.rs)));
      chk("fwd_b_sel", 32'(fwd_b_sel), 32'(m_sel(cur.rt)));
`endif
    end
    tr_pc.push_back(16'(pause_code));
    tr_bub.push_back(16'(idex_bubble));
    tr_flush.push_back(16'(ifid_flush));
`ifdef HAZARD_FORWARD_EN
    tr_sela.push_back(16'(fwd_a_sel));
    tr_selb.push_back(16'(fwd_b_sel));
`else
    tr_sela.push_back(16'(m_sel(cur.rs)));
    tr_selb.push_back(16'(m_sel(cur.rt)));
`endif
    tr_cnt.push_back(stall_cnt);
    tr_cnt2.push_back(16'(stall_cnt2));
    @(posedge clk);
    if (rst) begin
      hist  = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
      m_cnt = 0;
    end else begin
      e.v  = cur.valid && cur.we && cur.wd != 5'd0 && !estall && !eflush;
      e.r  = e.v ? cur.wd : 5'd0;
      e.ld = e.v ? cur.ld : 1'b0;
      hist.push_front(e);
      void'(hist.pop_back());
      if (estall) m_cnt++;
    end
    if (force_left > 0) force_left--;
    if (!estall) begin
      if (prog.size() > 0) cur = prog.pop_front();
      else if (random_mode) cur = rand_instr();
      else cur = NOP;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    prog.delete();
    cur     = NOP;
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    cyc     = 0;
    tr_pc.delete(); tr_bub.delete(); tr_flush.delete();
    tr_sela.delete(); tr_selb.delete(); tr_cnt.delete(); tr_cnt2.delete();
  endtask

  function automatic int sum_q(input logic [15:0] q[$], input bit nonzero);
    int s = 0;
    foreach (q[k]) s += nonzero ? int'(q[k] != 0) : int'(q[k]);
    return s;
  endfunction

  localparam int A_STALLS   = FWD ? 0 : 3;
  localparam int B_STALLS   = FWD ? 1 : 3;
  localparam int FLUSH_CYC  = FWD ? 2 : 4;
  localparam int RST_CYC    = FWD ? 1 : 2;

  initial begin
    hist       = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    m_cnt      = 0;
    cyc        = 0;
    force_left = 0;
    rst_req    = 1'b0;
    random_mode = 1'b0;
    checking   = 1'b0;
    rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_we = 0; id_wreg = 0;
    id_is_load = 0; pause_req = 0; redirect = 0;
    do_reset();
    checking = 1'b1;

    // Reset state
    step();
    chk("reset_pause_code", 32'(tr_pc[0]), 32'd0);
    chk("reset_stall_cnt", 32'(tr_cnt[0]), 32'd0);

    // addu $3,$1,$2 ; subu $4,$3,$5
    do_reset();
    cur = mk(1, 2, 1, 3, 0, 1, 1, 0);
    prog.push_back(mk(3, 5, 1, 4, 0, 1, 1, 0));
    run(7);
    chk("alu_rs_pause_cycles", 32'(sum_q(tr_pc, 1)), 32'(A_STALLS));
    chk("alu_rs_bubbles", 32'(sum_q(tr_bub, 0)), 32'(A_STALLS));
    chk("alu_rs_stall_cnt", 32'(tr_cnt[6]), 32'(A_STALLS));
    chk("alu_rs_first_code", 32'(tr_pc[1]), FWD ? 32'd0 : 32'd1);
`ifdef HAZARD_FORWARD_EN
    chk("alu_rs_fwd_a", 32'(tr_sela[1]), 32'd1);
`endif

    // lw $3,0($1) ; addu $4,$2,$3
    do_reset();
    cur = mk(1, 0, 1, 3, 1, 1, 0, 0);
    prog.push_back(mk(2, 3, 1, 4, 0, 1, 1, 0));
    run(7);
    chk("load_use_first_code", 32'(tr_pc[1]), 32'd2);
    chk("load_use_bubbles", 32'(sum_q(tr_bub, 0)), 32'(B_STALLS));
`ifdef HAZARD_FORWARD_EN
    chk("load_use_fwd_b", 32'(tr_selb[2]), 32'd2);
`endif

    // Writer to $0 then reader of $0
    do_reset();
    cur = mk(1, 2, 1, 0, 0, 1, 1, 0);
    prog.push_back(mk(0, 0, 1, 4, 0, 1, 1, 0));
    run(5);
    chk("zero_reg_codes", 32'(sum_q(tr_pc, 1)), 32'd0);
    chk("zero_reg_bubbles", 32'(sum_q(tr_bub, 0)), 32'd0);

    // Redirect while stalled, then redirect once the hazard clears
    do_reset();
    cur = mk(1, 0, 1, 3, 1, 1, 0, 0);
    prog.push_back(mk(3, 0, 0, 0, 0, 1, 0, 1));
    run(7);
    chk("redir_stalled_flush", 32'(tr_flush[1]), 32'd0);
    chk("redir_clear_flush", 32'(tr_flush[FLUSH_CYC]), 32'd1);
    chk("redir_flush_count", 32'(sum_q(tr_flush, 0)), 32'd1);

    // Reset in the middle of a stall
    do_reset();
    rst_at = RST_CYC;
    cur = mk(1, 0, 1, 3, 1, 1, 0, 0);
    prog.push_back(mk(3, 0, 1, 4, 0, 1, 0, 0));
    run(5);
    rst_at = -1;
    chk("rst_mid_stall_before", 32'(tr_bub[RST_CYC]), 32'd1);
    chk("rst_mid_stall_code", 32'(tr_pc[RST_CYC+1]), 32'd0);
    chk("rst_mid_stall_cnt", 32'(tr_cnt[RST_CYC+1]), 32'd0);

    // Five forced stalls: narrow counter saturates at 3
    do_reset();
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
    force_left = 5;
    run(6);
    chk("sat_cnt16", 32'(tr_cnt[5]), 32'd5);
    chk("sat_cnt2", 32'(tr_cnt2[5]), 32'd3);

    // Randomized traffic against the model
    do_reset();
    random_mode = 1'b1;
    cur = rand_instr();
    for (int k = 0; k < 3000; k++) begin
      rst_req = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) force_left = 1;
      step();
    end
    rst_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
